// File: rtl/cpu_pkg.sv
// Shared encodings for the operand-select pipeline: extension modes and handshake states.
package cpu_pkg;

  localparam logic [1:0] EXT_PASS = 2'b00;
  localparam logic [1:0] EXT_ZEXT = 2'b01;
  localparam logic [1:0] EXT_SEXT = 2'b10;
  localparam logic [1:0] EXT_ZERO = 2'b11;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

endpackage

// File: rtl/operand_extend.sv
// Combinational extension of the low NARROW_W bits of an operand: pass, zero/sign-extend or force-zero.
module operand_extend
  import cpu_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NARROW_W = 8
) (
  input  logic [DATA_W-1:0] s,
  input  logic [1:0]        ext_mode,
  output logic [DATA_W-1:0] ext
);

  always_comb begin
    ext = '0;
    case (ext_mode)
      EXT_PASS: ext = s;
      EXT_ZEXT: ext = {{(DATA_W-NARROW_W){1'b0}}, s[NARROW_W-1:0]};
      EXT_SEXT: ext = {{(DATA_W-NARROW_W){s[NARROW_W-1]}}, s[NARROW_W-1:0]};
      default:  ext = '0;
    endcase
  end

endmodule

// File: rtl/operand_select_pipe.sv
// Selects one of NUM_SRC operands, extends it, and registers it behind a valid/ready
// handshake with a 2-entry skid buffer (latency 1, in_ready registered).
module operand_select_pipe
  import cpu_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NARROW_W = 8,
  parameter int NUM_SRC  = 4,
  parameter int SEL_W    = $clog2(NUM_SRC)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  input  logic [SEL_W-1:0]          sel,
  input  logic [1:0]                ext_mode,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         out_data,
  output logic                      out_err
);

  logic [DATA_W-1:0] sel_src;
  logic [DATA_W-1:0] ext_val;
  logic [DATA_W-1:0] res_data;
  logic              res_err;
  logic              sel_ok;

  logic [DATA_W-1:0] main_data;
  logic              main_err;
  logic [DATA_W-1:0] skid_data;
  logic              skid_err;

  state_t state;
  state_t state_nxt;
  logic   acc;
  logic   drn;
  logic   load_main;
  logic   load_skid;
  logic   move_skid;

  always_comb begin
    sel_src = '0;
    sel_ok  = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (sel == SEL_W'(k)) begin
        sel_src = src_data[k*DATA_W +: DATA_W];
        sel_ok  = 1'b1;
      end
    end
  end

  operand_extend #(
    .DATA_W   (DATA_W),
    .NARROW_W (NARROW_W)
  ) u_extend (
    .s        (sel_src),
    .ext_mode (ext_mode),
    .ext      (ext_val)
  );

  // Out-of-range selects force zero data regardless of the extension mode.
  assign res_data = sel_ok ? ext_val : '0;
  assign res_err  = ~sel_ok;

  assign out_valid = (state != EMPTY);
  assign out_data  = main_data;
  assign out_err   = main_err;

  assign acc = in_valid && in_ready;
  assign drn = out_valid && out_ready;

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY: if (acc) state_nxt = ONE;
      ONE: begin
        if (acc && !drn)      state_nxt = TWO;
        else if (!acc && drn) state_nxt = EMPTY;
      end
      TWO:   if (drn) state_nxt = ONE;
      default: state_nxt = EMPTY;
    endcase
    if (flush) state_nxt = EMPTY;
  end

  // A new item goes straight to main unless main is occupied and stalled; TWO never accepts.
  assign load_main = !flush && acc && ((state == EMPTY) || drn);
  assign load_skid = !flush && acc && (state == ONE) && !drn;
  assign move_skid = !flush && (state == TWO) && drn;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= EMPTY;
      in_ready  <= 1'b1;
      main_data <= '0;
      main_err  <= 1'b0;
      skid_data <= '0;
      skid_err  <= 1'b0;
    end else begin
      state    <= state_nxt;
      in_ready <= (state_nxt != TWO);
      if (load_main) begin
        main_data <= res_data;
        main_err  <= res_err;
      end else if (move_skid) begin
        main_data <= skid_data;
        main_err  <= skid_err;
      end
      if (load_skid) begin
        skid_data <= res_data;
        skid_err  <= res_err;
      end
    end
  end

endmodule
